// File: rtl/scroll_tick_gen.sv
// Scroll rate generator: switch-selected tick rate, debounced pause/step keys.
// Optional step key path is compiled in when SCROLL_STEP_EN is defined.
module scroll_tick_gen #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [1:0] speed_sel,
  input  logic       pause_n,
  input  logic       step_n,
  output logic       tick,
  output logic       running
);

  localparam int PW = $clog2(2 * CLK_HZ);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [PW-1:0] P0_LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] P1_LAST = PW'(CLK_HZ / 2 - 1);
  localparam logic [PW-1:0] P2_LAST = PW'(CLK_HZ / 4 - 1);
  localparam logic [PW-1:0] P3_LAST = PW'(2 * CLK_HZ - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] PAUSED = 1'b1;

  logic [1:0] spd_s1;
  logic [1:0] spd_s2;
  logic [1:0] spd_q;
  logic       spd_chg;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      spd_s1 <= 2'd0;
      spd_s2 <= 2'd0;
      spd_q  <= 2'd0;
    end else begin
      spd_s1 <= speed_sel;
      spd_s2 <= spd_s1;
      spd_q  <= spd_s2;
    end
  end

  assign spd_chg = (spd_s2 != spd_q);

  logic          p_s1;
  logic          p_s2;
  logic          p_acc;
  logic [DW-1:0] p_cnt;
  logic          p_ev;
  logic          p_mis;

  assign p_mis = (p_s2 != p_acc);

  // Event fires on the same edge that acc accepts a low level.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      p_s1  <= 1'b1;
      p_s2  <= 1'b1;
      p_acc <= 1'b1;
      p_cnt <= '0;
      p_ev  <= 1'b0;
    end else begin
      p_s1 <= pause_n;
      p_s2 <= p_s1;
      p_ev <= p_mis && (p_cnt == DB_LAST) && !p_s2;
      if (!p_mis) begin
        p_cnt <= '0;
      end else if (p_cnt == DB_LAST) begin
        p_cnt <= '0;
        p_acc <= p_s2;
      end else begin
        p_cnt <= p_cnt + DW'(1);
      end
    end
  end

  logic s_ev;

`ifdef SCROLL_STEP_EN
  logic          s_s1;
  logic          s_s2;
  logic          s_acc;
  logic [DW-1:0] s_cnt;
  logic          s_mis;

  assign s_mis = (s_s2 != s_acc);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      s_s1  <= 1'b1;
      s_s2  <= 1'b1;
      s_acc <= 1'b1;
      s_cnt <= '0;
      s_ev  <= 1'b0;
    end else begin
      s_s1 <= step_n;
      s_s2 <= s_s1;
      s_ev <= s_mis && (s_cnt == DB_LAST) && !s_s2;
      if (!s_mis) begin
        s_cnt <= '0;
      end else if (s_cnt == DB_LAST) begin
        s_cnt <= '0;
        s_acc <= s_s2;
      end else begin
        s_cnt <= s_cnt + DW'(1);
      end
    end
  end
`else
  logic unused_step;
  assign unused_step = step_n;
  assign s_ev = 1'b0;
`endif

  logic [PW-1:0] p_last;
  logic [PW-1:0] pcnt;
  logic [0:0]    state;
  logic          wrap;

  always_comb begin
    p_last = P0_LAST;
    unique case (spd_q)
      2'd0: p_last = P0_LAST;
      2'd1: p_last = P1_LAST;
      2'd2: p_last = P2_LAST;
      2'd3: p_last = P3_LAST;
      default: p_last = P0_LAST;
    endcase
  end

  assign wrap = (pcnt == p_last);

  // Pause beats both a RUN wrap and a simultaneous step.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state   <= RUN;
      running <= 1'b1;
      tick    <= 1'b0;
      pcnt    <= '0;
    end else begin
      tick <= 1'b0;
      unique case (state)
        RUN: begin
          if (p_ev) begin
            state   <= PAUSED;
            running <= 1'b0;
            pcnt    <= '0;
          end else if (spd_chg) begin
            pcnt <= '0;
          end else if (wrap) begin
            pcnt <= '0;
            tick <= 1'b1;
          end else begin
            pcnt <= pcnt + PW'(1);
          end
        end
        PAUSED: begin
          pcnt <= '0;
          if (p_ev) begin
            state   <= RUN;
            running <= 1'b1;
          end else if (s_ev) begin
            tick <= 1'b1;
          end
        end
        default: begin
          state   <= RUN;
          running <= 1'b1;
          pcnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scroll_tick_gen.sv
// Directed bench for scroll_tick_gen at CLK_HZ=8, DEBOUNCE_CYCLES=4.
module tb_scroll_tick_gen;

  localparam int CLK_HZ = 8;
  localparam int DB     = 4;

  typedef struct {
    logic [1:0] spd;
    int         per;
  } rate_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] speed_sel = 2'd0;
  logic       pause_n = 1'b1;
  logic       step_n = 1'b1;
  logic       tick;
  logic       running;

  int cyc = 0;
  int tq[$];
  int tests = 0;
  int fails = 0;

  scroll_tick_gen #(
    .CLK_HZ(CLK_HZ),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .CLOCK_50(clk),
    .resetn(resetn),
    .speed_sel(speed_sel),
    .pause_n(pause_n),
    .step_n(step_n),
    .tick(tick),
    .running(running)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (tick) tq.push_back(cyc);
  end

  task automatic stepc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int cnt_ticks(input int lo, input int hi);
    int n = 0;
    foreach (tq[i]) if (tq[i] > lo && tq[i] <= hi) n++;
    return n;
  endfunction

  task automatic next_tick(input int after, input int budget, output int e);
    e = -1;
    for (int i = 0; i <= budget; i++) begin
      foreach (tq[j]) if (e < 0 && tq[j] > after) e = tq[j];
      if (e >= 0) return;
      stepc();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rate_t tbl[4];
    int e, b, c0, exp_step;
    tbl[0] = '{2'd2, 2};
    tbl[1] = '{2'd3, 16};
    tbl[2] = '{2'd1, 4};
    tbl[3] = '{2'd0, 8};
`ifdef SCROLL_STEP_EN
    exp_step = 1;
`else
    exp_step = 0;
`endif

    stepc(3);
    chk("reset_tick", tick, 0);
    chk("reset_running", running, 1);

    c0 = cyc;
    resetn = 1'b1;
    next_tick(c0, 40, e);
    chk("tick1_edge", e, c0 + 8);
    next_tick(e, 40, e);
    chk("tick2_edge", e, c0 + 16);
    next_tick(e, 40, e);
    chk("tick3_edge", e, c0 + 24);

    // Speed is sampled at c0+1, reaches spd_q at c0+3, first tick P later.
    foreach (tbl[i]) begin
      c0 = cyc;
      speed_sel = tbl[i].spd;
      next_tick(c0 + 2, 60, e);
      chk($sformatf("rate%0d_first", i), e, c0 + 3 + tbl[i].per);
      b = e;
      next_tick(b, 60, e);
      chk($sformatf("rate%0d_second", i), e, b + tbl[i].per);
      b = e;
      next_tick(b, 60, e);
      chk($sformatf("rate%0d_third", i), e, b + tbl[i].per);
      chk($sformatf("rate%0d_running", i), running, 1);
    end

    // Pause event lands on the wrap edge e+8: tick must be dropped.
    stepc(1);
    c0 = cyc;
    pause_n = 1'b0;
    stepc(6);
    chk("pause_before", running, 1);
    pause_n = 1'b1;
    stepc(1);
    chk("pause_running", running, 0);
    chk("pause_wrap_tick", cnt_ticks(c0, cyc), 0);
    stepc(100);
    chk("paused_no_ticks", cnt_ticks(c0, cyc), 0);
    chk("paused_running", running, 0);

    c0 = cyc;
    step_n = 1'b0;
    stepc(6);
    step_n = 1'b1;
    stepc(1);
    chk("step_tick_edge", cnt_ticks(c0 + 6, c0 + 7), exp_step);
    stepc(20);
    chk("step_tick_count", cnt_ticks(c0, cyc), exp_step);
    chk("step_running", running, 0);

    c0 = cyc;
    pause_n = 1'b0;
    step_n = 1'b0;
    stepc(6);
    pause_n = 1'b1;
    step_n = 1'b1;
    stepc(1);
    chk("simul_running", running, 1);
    chk("simul_no_tick", cnt_ticks(c0, cyc), 0);
    next_tick(cyc, 40, e);
    chk("resume_first_tick", e, c0 + 15);

    b = e;
    step_n = 1'b0;
    stepc(6);
    step_n = 1'b1;
    next_tick(b, 40, e);
    chk("run_step_t1", e, b + 8);
    next_tick(e, 40, e);
    chk("run_step_t2", e, b + 16);
    next_tick(e, 40, e);
    chk("run_step_t3", e, b + 24);

    repeat (5) begin
      pause_n = 1'b0;
      stepc(3);
      pause_n = 1'b1;
      stepc(3);
    end
    stepc(10);
    chk("bounce_running", running, 1);

    c0 = cyc;
    pause_n = 1'b0;
    stepc(6);
    chk("hold6_before", running, 1);
    pause_n = 1'b1;
    stepc(1);
    chk("hold6_running", running, 0);
    stepc(30);
    chk("release_no_event", running, 0);

    resetn = 1'b0;
    #1;
    chk("rst_async_running", running, 1);
    chk("rst_async_tick", tick, 0);
    stepc(3);
    c0 = cyc;
    resetn = 1'b1;
    next_tick(c0, 40, e);
    chk("rst1_first_tick", e, c0 + 8);

    chk("pre_rst_tick_high", tick, 1);
    resetn = 1'b0;
    #1;
    chk("rst2_async_tick", tick, 0);
    stepc(2);
    c0 = cyc;
    resetn = 1'b1;
    next_tick(c0, 40, e);
    chk("rst2_first_tick", e, c0 + 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
